// File: rtl/rgb_pwm_seq.sv
// Three-channel RGB LED PWM driver with bias-settle power sequencing.
// Shadow duties are copied into the active compare registers only at period wrap while running.
module rgb_pwm_seq #(
  parameter int SETTLE_CYC = 64,
  parameter int DUTY_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DUTY_W-1:0] wr_data,
  output logic [2:0]        rgb_pwm,
  output logic              rgbled_en,
  output logic [1:0]        state,
  output logic              period_done
);
  localparam int SETTLE_W = 16;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [DUTY_W-1:0]   CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_BIAS_ON = 2'd1,
    S_RUN     = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [SETTLE_W-1:0] settle_reg, settle_next;
  logic [DUTY_W-1:0]   presc_reg, presc_next;
  logic [DUTY_W-1:0]   presc_cnt_reg, presc_cnt_next;
  logic [DUTY_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]          rgb_pwm_reg;
  logic                rgbled_en_reg;
  logic                period_done_reg;
  logic                tick, wrap, restart, load_act, presc_wr;
  logic [2:0]          cmp;

  assign presc_wr = wr_en && (wr_addr == 2'd3);
  assign tick     = (state_reg == S_RUN) && (presc_cnt_reg == presc_reg);
  assign wrap     = tick && (cnt_reg == CNT_MAX);
  assign restart  = (state_next == S_RUN) && (state_reg != S_RUN);
  // While idle the active copies track the shadows; while running they change only at wrap.
  assign load_act = (state_reg == S_OFF) || (state_reg == S_BIAS_ON) || wrap;

  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    case (state_reg)
      S_OFF: begin
        if (enable) begin
          state_next  = S_BIAS_ON;
          settle_next = SETTLE_LOAD;
        end
      end
      S_BIAS_ON: begin
        if (!enable)                 state_next  = S_OFF;
        else if (settle_reg == '0)   state_next  = S_RUN;
        else                         settle_next = settle_reg - 1'b1;
      end
      S_RUN: begin
        if (!enable) begin
          state_next  = S_DRAIN;
          settle_next = SETTLE_LOAD;
        end
      end
      S_DRAIN: begin
        if (enable)                  state_next  = S_RUN;
        else if (settle_reg == '0)   state_next  = S_OFF;
        else                         settle_next = settle_reg - 1'b1;
      end
      default: state_next = S_OFF;
    endcase
  end

  always_comb begin
    cnt_next       = cnt_reg;
    presc_cnt_next = presc_cnt_reg;
    presc_next     = presc_write_value();
    if (restart) begin
      cnt_next       = '0;
      presc_cnt_next = '0;
    end else begin
      if (tick) begin
        cnt_next       = cnt_reg + 1'b1;
        presc_cnt_next = '0;
      end else if (state_reg == S_RUN) begin
        presc_cnt_next = presc_cnt_reg + 1'b1;
      end
      if (presc_wr) presc_cnt_next = '0;
    end
  end

  function automatic logic [DUTY_W-1:0] presc_write_value();
    return presc_wr ? wr_data : presc_reg;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [DUTY_W-1:0] shadow_reg, shadow_next, active_reg;

      always_comb begin
        shadow_next = shadow_reg;
        if (wr_en && (wr_addr == 2'(gi))) shadow_next = wr_data;
      end

      // Loading from shadow_next lets a write on the wrap cycle land in that same load.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          shadow_reg <= shadow_next;
          if (load_act) active_reg <= shadow_next;
        end
      end

      assign cmp[gi] = (cnt_reg < active_reg);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_OFF;
      settle_reg      <= '0;
      presc_reg       <= '0;
      presc_cnt_reg   <= '0;
      cnt_reg         <= '0;
      rgb_pwm_reg     <= '0;
      rgbled_en_reg   <= 1'b0;
      period_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      settle_reg      <= settle_next;
      presc_reg       <= presc_next;
      presc_cnt_reg   <= presc_cnt_next;
      cnt_reg         <= cnt_next;
      // Gate on both current and next state so the pads go dark on the edge RUN is left.
      rgb_pwm_reg     <= ((state_reg == S_RUN) && (state_next == S_RUN)) ? cmp : 3'b000;
      rgbled_en_reg   <= (state_next != S_OFF);
      period_done_reg <= wrap;
    end
  end

  assign rgb_pwm     = rgb_pwm_reg;
  assign rgbled_en   = rgbled_en_reg;
  assign state       = state_reg;
  assign period_done = period_done_reg;

endmodule

// File: doc/rgb_pwm_seq.md
RGB_PWM_SEQ -- requirements
Module: rgb_pwm_seq

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 64: the bias-settle wait in clocks, range 2..65535.
REQ-002 The block SHALL have parameter DUTY_W, default 8: the duty and PWM counter width.
REQ-003 Port clk  input  1: the single block clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port enable  input  1: master LED enable, level-sensitive.
REQ-006 Port wr_en  input  1: register write strobe, one write per cycle.
REQ-007 Port wr_addr  input  2: register select; 0/1/2 select duty0/duty1/duty2 and 3 selects presc.
REQ-008 Port wr_data  input  DUTY_W: register write data.
REQ-009 Port rgb_pwm  output  3: per-channel PWM gate to the RGB pad drivers, registered.
REQ-010 Port rgbled_en  output  1: LED bias enable to the bias generator, registered.
REQ-011 Port state  output  2: FSM state; OFF=0, BIAS_ON=1, RUN=2, DRAIN=3.
REQ-012 Port period_done  output  1: one-clock pulse at each PWM period wrap in RUN.

Function
REQ-013 Registers SHALL hold shadow duty0..2 and presc; a write updates the addressed register on the clock edge where wr_en=1.
REQ-014 The block SHALL keep an active duty copy per channel; the PWM compare SHALL use only the active copies.
REQ-015 In OFF and BIAS_ON, each active duty SHALL follow its shadow every cycle.
REQ-016 In RUN and DRAIN, active duties SHALL load from the shadows only on the wrap cycle, so updates are glitch-free.
REQ-017 A shadow write coinciding with the wrap cycle SHALL reach the active copy in that same load.
REQ-018 The prescaler SHALL issue a tick every presc+1 clocks while in RUN; presc=0 SHALL tick every clock.
REQ-019 A write to presc SHALL take effect immediately and SHALL clear the prescaler count to 0.
REQ-020 The PWM counter cnt (DUTY_W bits) SHALL increment on each tick in RUN and wrap from 2^DUTY_W-1 to 0.
REQ-021 The wrap cycle SHALL be the tick with cnt=2^DUTY_W-1; period_done SHALL pulse on the following clock.
REQ-022 In RUN, rgb_pwm[i] SHALL be registered (cnt < active duty_i), giving one clock of compare latency.
REQ-023 Duty 0 SHALL keep the channel always low; duty 2^DUTY_W-1 SHALL drive high for 255 of 256 ticks.
REQ-024 rgb_pwm SHALL be 0 in every state other than RUN.
REQ-025 OFF: rgbled_en=0; enable=1 SHALL move the FSM to BIAS_ON and load the settle counter.
REQ-026 BIAS_ON: rgbled_en=1; after exactly SETTLE_CYC clocks the FSM SHALL enter RUN with cnt=0 and prescaler=0.
REQ-027 enable=0 in BIAS_ON SHALL return the FSM to OFF on the next clock.
REQ-028 RUN: enable=0 SHALL enter DRAIN; rgb_pwm SHALL be 0 from the next clock, and cnt and the prescaler SHALL freeze.
REQ-029 DRAIN: rgbled_en SHALL stay 1 for SETTLE_CYC clocks, after which the FSM SHALL enter OFF.
REQ-030 enable=1 during DRAIN SHALL return the FSM to RUN on the next clock with cnt=0 and prescaler=0, with no new settle.
REQ-031 All outputs SHALL be driven from flops; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-032 On rst_n=0, asynchronously: state=OFF, rgb_pwm=0, rgbled_en=0, period_done=0, cnt=0, prescaler=0, settle counter=0, all duties=0, presc=0.
REQ-033 Reset asserted mid-RUN or mid-DRAIN SHALL drop rgbled_en and rgb_pwm to 0 immediately, with no drain sequence.
REQ-034 After rst_n deasserts, the block SHALL wait in OFF until enable=1.

Verification
REQ-035 Scenario: duty0=64, duty1=0, duty2=255, presc=0, enable=1 -> rgbled_en rises next clock; RUN after 64 clocks; per 256-clock period, rgb_pwm[0] high 64, rgb_pwm[1] high 0, rgb_pwm[2] high 255; period_done once per 256 clocks.
REQ-036 Scenario: duty0=128 written mid-period in RUN -> the old duty holds until wrap; 128 applies from the next period with no partial-width pulse.
REQ-037 Scenario: presc=3 -> tick every 4 clocks; period is 1024 clocks; duty0=64 gives 256 high clocks.
REQ-038 Scenario: enable drops in RUN -> rgb_pwm=0 next clock; rgbled_en=1 for 64 more clocks; then state=OFF. Re-raising enable during DRAIN -> RUN next clock with cnt=0.
REQ-039 Scenario: rst_n pulsed low mid-RUN -> all outputs 0 asynchronously; state=0; duties read back as 0 (channel stays dark on re-enable).
REQ-040 Scenario: enable toggled 1 then 0 within BIAS_ON -> back to OFF; rgb_pwm never asserts.
